// File: rtl/fixed_to_float_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_float_pkg
// Description : Shared constants for the fixed-point to IEEE-754 single
//               converter: exponent bias, float field positions and the
//               FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_to_float_pkg;

    // IEEE-754 single-precision layout
    localparam int c_BIAS     = 127;
    localparam int c_SIGN_BIT = 31;
    localparam int c_EXP_MSB  = 30;
    localparam int c_EXP_LSB  = 23;
    localparam int c_MAN_MSB  = 22;
    localparam int c_MAN_LSB  = 0;
    localparam int c_EXP_W    = c_EXP_MSB - c_EXP_LSB + 1;
    localparam int c_MAN_W    = c_MAN_MSB - c_MAN_LSB + 1;

    // Converter FSM states
    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE = 1'b0;
    localparam state_t c_ST_NORM = 1'b1;

endpackage : fixed_to_float_pkg
`default_nettype wire

// File: rtl/fixed_to_float_abs.sv
`default_nettype none
// ============================================================================
// Module      : Abs_32Bits
// Description : Combinational two's-complement magnitude of a 32-bit value.
//               The most negative input (0x80000000) yields 0x80000000,
//               which is its correct magnitude when read as unsigned.
// Ports       : i_value - signed 32-bit operand
//               o_mag   - unsigned 32-bit magnitude
// Revision    : 1.0 - initial release
// ============================================================================
module Abs_32Bits (
    input  logic [31:0] i_value,
    output logic [31:0] o_mag
);

    assign o_mag = i_value[31] ? (~i_value + 32'd1) : i_value;

endmodule : Abs_32Bits
`default_nettype wire

// File: rtl/fixed_to_float.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_float
// Description : Multi-cycle converter from signed fixed point (FRAC fraction
//               bits) to IEEE-754 single precision. The magnitude is
//               normalised one bit per cycle, then packed with truncation.
// Ports       : CLK       - clock, rising edge
//               RST       - synchronous active-high reset
//               START     - request a conversion (sampled only when idle)
//               FIXED     - signed fixed-point operand
//               FLOAT     - packed result, held until the next DONE
//               BUSY      - conversion in progress
//               DONE      - one-cycle pulse, FLOAT valid
//               SHIFT_CNT - normalisation shift count
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_to_float
    import fixed_to_float_pkg::*;
#(
    parameter int P    = 32,
    parameter int FRAC = 26
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [P-1:0] FIXED,
    output logic [P-1:0] FLOAT,
    output logic         BUSY,
    output logic         DONE,
    output logic [4:0]   SHIFT_CNT
);

    // Exponent when the MSB of the magnitude is already set (no shift).
    localparam logic [c_EXP_W-1:0] c_EXP_TOP = c_EXP_W'(c_BIAS + (P - 1 - FRAC));

    state_t               r_state, w_state_nxt;
    logic [P-1:0]         r_mag, w_mag_nxt;
    logic                 r_sign, w_sign_nxt;
    logic [P-1:0]         r_float, w_float_nxt;
    logic [4:0]           r_shift, w_shift_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic [P-1:0]         w_abs;
    logic [c_EXP_W-1:0]   w_exp;
    logic [P-1:0]         w_packed;

    Abs_32Bits u_abs (
        .i_value (FIXED),
        .o_mag   (w_abs)
    );

    // Leading one is implicit; the 23 bits below it become the mantissa,
    // lower bits are dropped (round toward zero).
    assign w_exp    = c_EXP_TOP - c_EXP_W'(r_shift);
    assign w_packed = {r_sign, w_exp, r_mag[P-2 -: c_MAN_W]};

    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_sign_nxt  = r_sign;
        w_float_nxt = r_float;
        w_shift_nxt = r_shift;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (START) begin
                w_mag_nxt   = w_abs;
                w_sign_nxt  = FIXED[P-1];
                w_shift_nxt = 5'd0;
                w_busy_nxt  = 1'b1;
                w_state_nxt = c_ST_NORM;
            end
        end else begin
            if (r_mag == '0) begin
                // Zero has no leading one; emit +0 regardless of sign.
                w_float_nxt = '0;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end else if (r_mag[P-1]) begin
                w_float_nxt = w_packed;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end else begin
                w_mag_nxt   = r_mag << 1;
                w_shift_nxt = r_shift + 5'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
            r_mag   <= '0;
            r_sign  <= 1'b0;
            r_float <= '0;
            r_shift <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mag   <= w_mag_nxt;
            r_sign  <= w_sign_nxt;
            r_float <= w_float_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign FLOAT     = r_float;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign SHIFT_CNT = r_shift;

endmodule : fixed_to_float
`default_nettype wire

// File: tb/tb_fixed_to_float.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_to_float
// Description : Self-checking bench for fixed_to_float. Expected results come
//               from real-number arithmetic on the operand value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_to_float;

    localparam int c_FRAC = 26;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] fixed_in;
    logic [31:0] float_out;
    logic        busy;
    logic        done;
    logic [4:0]  shift_cnt;

    int checks = 0;
    int errors = 0;

    fixed_to_float #(.P(32), .FRAC(c_FRAC)) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .FIXED     (fixed_in),
        .FLOAT     (float_out),
        .BUSY      (busy),
        .DONE      (done),
        .SHIFT_CNT (shift_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = signed(fx) / 2^FRAC as a real; take the double's
    // sign, rebias its exponent, and keep the top 23 fraction bits
    // (the double holds any 32-bit integer exactly, so this truncates).
    function automatic logic [31:0] model_float(input logic [31:0] fx);
        real         r;
        logic [63:0] b;
        int          e;
        logic [7:0]  e8;
        if (fx == 32'd0) return 32'd0;
        r  = $itor($signed(fx)) / (2.0 ** c_FRAC);
        b  = $realtobits(r);
        e  = int'(b[62:52]) - 1023 + 127;
        e8 = e[7:0];
        return {b[63], e8, b[51:29]};
    endfunction

    // Number of doublings needed to bring |fx| up to at least 2^31.
    function automatic int model_lz(input logic [31:0] fx);
        longint m;
        int     k;
        m = longint'($signed(fx));
        if (m < 0) m = -m;
        if (m == 0) return 0;
        k = 0;
        while (m < 64'sd2147483648) begin
            m = m * 2;
            k++;
        end
        return k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one conversion, toggle START/FIXED randomly while busy, and
    // check latency, result, flags and the single-cycle DONE pulse.
    task automatic run_one(input logic [31:0] fx, input string tag);
        int n;
        int k;
        int lat;
        k   = model_lz(fx);
        lat = (fx == 32'd0) ? 1 : k + 1;
        start = 1'b1; fixed_in = fx;
        @(posedge clk); #1;
        start = 1'b0; fixed_in = $urandom;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            start = 1'($urandom_range(0, 1));
            fixed_in = $urandom;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, lat);
        check({tag, "_float"}, float_out, model_float(fx));
        check({tag, "_shift"}, 32'(shift_cnt), k);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] fx;
        logic [31:0] acc;
        int n;
        int k;
        int dcount;

        rst = 1'b1; start = 1'b0; fixed_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_float", float_out, 32'd0);
        check("rst_shift", 32'(shift_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed values with literal expectations
        run_one(32'h04000000, "one");
        check("one_lit", float_out, 32'h3F800000);
        run_one(32'h0E000000, "three_half");
        check("three_half_lit", float_out, 32'h40600000);
        run_one(32'hFD000000, "neg_3q");
        check("neg_3q_lit", float_out, 32'hBF400000);
        run_one(32'h80000000, "most_neg");
        check("most_neg_lit", float_out, 32'hC2000000);
        run_one(32'h00000001, "lsb");
        check("lsb_lit", float_out, 32'h32800000);
        run_one(32'h00000000, "zero");
        check("zero_lit", float_out, 32'h00000000);
        run_one(32'h7FFFFFFF, "max_pos");
        run_one(32'hFFFFFFFF, "neg_lsb");

        // Random operands spread over all magnitudes
        for (int i = 0; i < 20; i++) begin
            fx = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) fx = -fx;
            run_one(fx, "rand");
        end

        // START held high with FIXED changing every cycle
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            acc = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) acc = -acc;
            fixed_in = acc;
            @(posedge clk); #1;
            check("stream_busy", 32'(busy), 32'd1);
            check("stream_done_low", 32'(done), 32'd0);
            n = 0;
            while (!done && n < 40) begin
                fixed_in = $urandom;
                @(posedge clk); #1;
                n++;
            end
            k = model_lz(acc);
            check("stream_latency", n, (acc == 32'd0) ? 1 : k + 1);
            check("stream_float", float_out, model_float(acc));
            check("stream_shift", 32'(shift_cnt), k);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a long conversion
        start = 1'b1; fixed_in = 32'h00000001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_float", float_out, 32'd0);
        check("midrst_shift", 32'(shift_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("midrst_no_done", dcount, 0);
        run_one(32'h04000000, "after_rst");
        check("after_rst_lit", float_out, 32'h3F800000);

        // Reset wins over START
        rst = 1'b1; start = 1'b1; fixed_in = 32'h04000000;
        @(posedge clk); #1;
        check("rst_prio_busy", 32'(busy), 32'd0);
        check("rst_prio_float", float_out, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_prio_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fixed_to_float
`default_nettype wire
